// File: rtl/prbs_stim_gen.sv
// prbs_stim_gen: PRBS-15 (x^15+x^14+1) stimulus source feeding the sim DUT.
// Emits one WIDTH-bit symbol every DIV clocks in bursts or continuously.
//
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   start      - begin a burst (honoured in IDLE or DONE only)
//   stop       - abort the current burst (honoured in RUN only)
//   d          - current symbol, held between strobes
//   d_valid    - one-cycle pulse in the cycle d updates
//   a          - toggles on every emitted symbol
//   busy       - high while running
//   done       - high once a finite burst has completed
//   sym_count  - symbols emitted in the current burst
module prbs_stim_gen #(
   parameter int          WIDTH   = 4,
   parameter int          DIV     = 4,
   parameter int          NUM_SYM = 16,
   parameter logic [14:0] SEED    = 15'h4000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] d,
   output logic             d_valid,
   output logic             a,
   output logic             busy,
   output logic             done,
   output logic [15:0]      sym_count
);

   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
   localparam logic [14:0] SEED_EFF =
      (SEED == 15'd0) ? 15'h0001 : SEED;
   localparam bit BURST = (NUM_SYM != 0);
   localparam logic [15:0] SYM_LAST = 16'(NUM_SYM - 1);

   if (WIDTH < 1 || WIDTH > 15) begin : g_width_chk
      $error("prbs_stim_gen: WIDTH must be 1..15");
   end
   if (DIV < 1) begin : g_div_chk
      $error("prbs_stim_gen: DIV must be >= 1");
   end
   if (NUM_SYM < 0 || NUM_SYM > 65535) begin : g_num_chk
      $error("prbs_stim_gen: NUM_SYM must be 0..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_n;

   logic [14:0]      lfsr_q;
   logic [14:0]      lfsr_n;
   logic [DCW-1:0]   div_q;
   logic [DCW-1:0]   div_n;
   logic [WIDTH-1:0] d_n;
   logic             dv_n;
   logic             a_n;
   logic             busy_n;
   logic             done_n;
   logic [15:0]      cnt_n;

   logic launch;
   logic strobe;
   logic emit;
   logic last;

   // One symbol's worth of LFSR steps.
   function automatic logic [14:0] lfsr_adv(input logic [14:0] s);
      logic [14:0] t;
      t = s;
      for (int i = 0; i < WIDTH; i++) begin
         t = {t[13:0], t[14] ^ t[13]};
      end
      return t;
   endfunction

   logic [14:0] lfsr_step;
   assign lfsr_step = lfsr_adv(lfsr_q);

   assign launch = start && (state_q == IDLE || state_q == DONE);
   assign strobe = (state_q == RUN) && (div_q == DIV_LAST);
   // stop outranks a coincident strobe: no symbol is emitted.
   assign emit   = strobe && !stop;
   assign last   = BURST && (sym_count == SYM_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_n = RUN;
         end
         RUN: begin
            if (stop)              state_n = IDLE;
            else if (strobe && last) state_n = DONE;
         end
         DONE: begin
            if (start) state_n = RUN;
         end
         default: state_n = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      lfsr_n = lfsr_q;
      div_n  = '0;
      d_n    = d;
      dv_n   = 1'b0;
      a_n    = a;
      cnt_n  = sym_count;
      busy_n = (state_n == RUN);
      done_n = (state_n == DONE);

      if (launch) begin
         cnt_n = 16'd0;
      end else if (state_q == RUN && !stop) begin
         div_n = strobe ? '0 : div_q + DCW'(1);
      end

      if (emit) begin
         lfsr_n = lfsr_step;
         d_n    = lfsr_step[WIDTH-1:0];
         dv_n   = 1'b1;
         a_n    = ~a;
         cnt_n  = sym_count + 16'd1;
      end
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q    <= SEED_EFF;
         div_q     <= '0;
         d         <= '0;
         d_valid   <= 1'b0;
         a         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sym_count <= 16'd0;
      end else begin
         lfsr_q    <= lfsr_n;
         div_q     <= div_n;
         d         <= d_n;
         d_valid   <= dv_n;
         a         <= a_n;
         busy      <= busy_n;
         done      <= done_n;
         sym_count <= cnt_n;
      end
   end

endmodule

// File: tb/tb_prbs_stim_gen.sv
// tb_prbs_stim_gen: directed bench for prbs_stim_gen.
// Three instances cover default, short-burst and continuous configurations.
module tb_prbs_stim_gen;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic start0 = 0, stop0 = 0;
   logic start1 = 0, stop1 = 0;
   logic start2 = 0, stop2 = 0;

   logic [3:0]  d0, d1, d2;
   logic        dv0, dv1, dv2;
   logic        a0, a1, a2;
   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;
   logic [15:0] cnt0, cnt1, cnt2;

   prbs_stim_gen u0 (
      .clk(clk), .reset(reset), .start(start0), .stop(stop0),
      .d(d0), .d_valid(dv0), .a(a0), .busy(busy0), .done(done0),
      .sym_count(cnt0)
   );

   prbs_stim_gen #(.DIV(2), .NUM_SYM(3)) u1 (
      .clk(clk), .reset(reset), .start(start1), .stop(stop1),
      .d(d1), .d_valid(dv1), .a(a1), .busy(busy1), .done(done1),
      .sym_count(cnt1)
   );

   prbs_stim_gen #(.DIV(1), .NUM_SYM(0)) u2 (
      .clk(clk), .reset(reset), .start(start2), .stop(stop2),
      .d(d2), .d_valid(dv2), .a(a2), .busy(busy2), .done(done2),
      .sym_count(cnt2)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [14:0] lfsr4(input logic [14:0] s);
      logic [14:0] t;
      t = s;
      for (int i = 0; i < 4; i++) t = {t[13:0], t[14] ^ t[13]};
      return t;
   endfunction

   typedef struct {
      logic        st;
      logic        sp;
      logic        rs;
      logic        dv;
      logic [3:0]  d;
      logic        a;
      logic        busy;
      logic        done;
      logic [15:0] cnt;
   } vec_t;

   function automatic vec_t mk(input logic st, sp, rs, dv,
                               input logic [3:0] d,
                               input logic a, busy, done,
                               input logic [15:0] cnt);
      vec_t v;
      v.st = st; v.sp = sp; v.rs = rs; v.dv = dv; v.d = d;
      v.a = a; v.busy = busy; v.done = done; v.cnt = cnt;
      return v;
   endfunction

   vec_t tbl[32];

   initial begin
      logic [14:0] m;
      logic [23:0] exp_v;
      logic [15:0] n16;

      //            st sp rs dv d     a  bz dn cnt
      tbl[0]  = mk(0, 0, 1, 0, 4'h0, 0, 0, 0, 16'd0);
      tbl[1]  = mk(1, 0, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[2]  = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[3]  = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[4]  = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[5]  = mk(0, 0, 0, 1, 4'h8, 1, 1, 0, 16'd1);
      tbl[6]  = mk(0, 0, 0, 0, 4'h8, 1, 1, 0, 16'd1);
      tbl[7]  = mk(0, 0, 0, 0, 4'h8, 1, 1, 0, 16'd1);
      tbl[8]  = mk(0, 0, 0, 0, 4'h8, 1, 1, 0, 16'd1);
      tbl[9]  = mk(0, 1, 0, 0, 4'h8, 1, 0, 0, 16'd1);
      tbl[10] = mk(0, 0, 0, 0, 4'h8, 1, 0, 0, 16'd1);
      tbl[11] = mk(0, 1, 0, 0, 4'h8, 1, 0, 0, 16'd1);
      tbl[12] = mk(1, 0, 0, 0, 4'h8, 1, 1, 0, 16'd0);
      tbl[13] = mk(0, 0, 0, 0, 4'h8, 1, 1, 0, 16'd0);
      tbl[14] = mk(0, 0, 0, 0, 4'h8, 1, 1, 0, 16'd0);
      tbl[15] = mk(0, 0, 0, 0, 4'h8, 1, 1, 0, 16'd0);
      tbl[16] = mk(0, 0, 0, 1, 4'h0, 0, 1, 0, 16'd1);
      tbl[17] = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd1);
      tbl[18] = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd1);
      tbl[19] = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd1);
      tbl[20] = mk(0, 0, 0, 1, 4'h0, 1, 1, 0, 16'd2);
      tbl[21] = mk(0, 0, 0, 0, 4'h0, 1, 1, 0, 16'd2);
      tbl[22] = mk(0, 0, 0, 0, 4'h0, 1, 1, 0, 16'd2);
      tbl[23] = mk(0, 0, 0, 0, 4'h0, 1, 1, 0, 16'd2);
      tbl[24] = mk(0, 0, 0, 1, 4'h3, 0, 1, 0, 16'd3);
      tbl[25] = mk(0, 0, 0, 0, 4'h3, 0, 1, 0, 16'd3);
      tbl[26] = mk(0, 0, 1, 0, 4'h0, 0, 0, 0, 16'd0);
      tbl[27] = mk(1, 1, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[28] = mk(1, 0, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[29] = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[30] = mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 16'd0);
      tbl[31] = mk(0, 0, 0, 1, 4'h8, 1, 1, 0, 16'd1);

      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Default instance: latency, stop-at-strobe, restart, reset.
      for (int i = 0; i < 32; i++) begin
         start0 = tbl[i].st;
         stop0  = tbl[i].sp;
         reset  = tbl[i].rs;
         tick();
         check($sformatf("vec%0d", i),
               64'({dv0, d0, a0, busy0, done0, cnt0}),
               64'({tbl[i].dv, tbl[i].d, tbl[i].a, tbl[i].busy,
                    tbl[i].done, tbl[i].cnt}));
      end
      start0 = 0; stop0 = 0; reset = 0;

      // Short burst: NUM_SYM=3, DIV=2, then 20 quiet clocks.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("burst_go", 64'({busy1, done1, dv1}), 64'(3'b100));
      for (int c = 1; c <= 26; c++) begin
         tick();
         check($sformatf("burst_c%0d", c),
               64'({dv1, busy1, done1}),
               64'({(c == 2 || c == 4 || c == 6), (c < 6), (c >= 6)}));
      end
      check("burst_cnt", 64'(cnt1), 64'(16'd3));
      check("burst_d", 64'({d1, a1}), 64'({4'h0, 1'b1}));

      // Restart from DONE continues the sequence (symbol 4 = 3).
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("redo_go", 64'({busy1, done1, cnt1}), 64'({2'b10, 16'd0}));
      tick();
      check("redo_wait", 64'(dv1), 64'(1'b0));
      tick();
      check("redo_sym", 64'({dv1, d1, cnt1}), 64'({1'b1, 4'h3, 16'd1}));

      // Continuous, DIV=1: every cycle a symbol, count wraps.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("cont_rst", 64'({dv2, d2, a2, busy2, done2, cnt2}), 64'(0));
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("cont_go", 64'({busy2, dv2, cnt2}), 64'({2'b10, 16'd0}));
      m = 15'h4000;
      for (int n = 1; n <= 65537; n++) begin
         tick();
         m = lfsr4(m);
         n16 = 16'(n);
         exp_v = {1'b1, m[3:0], n16[0], 1'b1, 1'b0, n16};
         check($sformatf("cont_n%0d", n),
               64'({dv2, d2, a2, busy2, done2, cnt2}), 64'(exp_v));
         if (n == 32768) check("period_s1", 64'(d2), 64'(4'h8));
         if (n == 32771) check("period_s4", 64'(d2), 64'(4'h3));
         if (n == 65536) check("wrap_cnt", 64'(cnt2), 64'(16'h0000));
      end
      stop2 = 1'b1;
      tick();
      stop2 = 1'b0;
      check("cont_stop", 64'({busy2, done2, dv2}), 64'(3'b000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
